// File: rtl/core_pkg.sv
// Types and constants shared by the MNIST accelerator core stages.
package core_pkg;

    localparam int LAYER4_WIDTH = 10;
    localparam int NUM_CLASSES  = LAYER4_WIDTH;
    localparam int LOGIT_WIDTH  = 16;

    typedef logic signed [LOGIT_WIDTH-1:0] logit_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_t;

endpackage

// File: rtl/logit_buffer.sv
// One-entry holding register for a logit vector that arrives while a scan is running.
module logit_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         take,
    input  logic signed [DATA_WIDTH-1:0] wr_data [NUM_CLASSES],
    output logic                         valid,
    output logic signed [DATA_WIDTH-1:0] data    [NUM_CLASSES]
);

    // A take and load in the same cycle hands out the old entry and keeps the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data[gi] <= '0;
                end else if (load) begin
                    data[gi] <= wr_data[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/argmax_classifier.sv
// Serial argmax over the final-layer logits: one signed compare per cycle, lowest index wins ties.
module argmax_classifier
    import core_pkg::*;
#(
    parameter int DATA_WIDTH  = LOGIT_WIDTH,
    parameter int NUM_CLASSES = core_pkg::NUM_CLASSES,
    parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] logits [NUM_CLASSES],
    output logic                         i_ready,
    output logic                         o_valid,
    output logic [IDX_WIDTH-1:0]         digit,
    output logic signed [DATA_WIDTH-1:0] max_logit,
    output logic                         overflow
);

    argmax_state_t               state;
    logic signed [DATA_WIDTH-1:0] work     [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] pend_data [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] src      [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] best_val;
    logic signed [DATA_WIDTH-1:0] cand;
    logic signed [DATA_WIDTH-1:0] next_val;
    logic [IDX_WIDTH-1:0]         best_idx;
    logic [IDX_WIDTH-1:0]         next_idx;
    logic [IDX_WIDTH-1:0]         cnt;
    logic                         pend_valid;
    logic                         pend_load;
    logic                         pend_take;
    logic                         drop;
    logic                         start;
    logic                         last;

    assign i_ready = !pend_valid;

    // In DONE a pending vector is served first; a coincident input refills the buffer.
    assign pend_take = (state == DONE) && pend_valid;
    assign pend_load = i_valid && (((state == SCAN) && !pend_valid) ||
                                   ((state == DONE) && pend_valid));
    assign drop      = i_valid && (state == SCAN) && pend_valid;
    assign start     = ((state == IDLE) && i_valid) ||
                       ((state == DONE) && (pend_valid || i_valid));

    always_comb begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            src[i] = pend_valid ? pend_data[i] : logits[i];
        end
    end

    assign cand     = work[cnt];
    assign next_val = (cand > best_val) ? cand : best_val;
    assign next_idx = (cand > best_val) ? cnt : best_idx;
    assign last     = (cnt == IDX_WIDTH'(NUM_CLASSES - 1));

    logit_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_CLASSES (NUM_CLASSES)
    ) u_pending (
        .clk     (clk),
        .rst     (rst),
        .load    (pend_load),
        .take    (pend_take),
        .wr_data (logits),
        .valid   (pend_valid),
        .data    (pend_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            o_valid   <= 1'b0;
            digit     <= '0;
            max_logit <= '0;
            overflow  <= 1'b0;
            best_val  <= '0;
            best_idx  <= '0;
            cnt       <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                work[i] <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
            end

            if (start) begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    work[i] <= src[i];
                end
                best_val <= src[0];
                best_idx <= '0;
                cnt      <= IDX_WIDTH'(1);
                state    <= SCAN;
            end else begin
                case (state)
                    SCAN: begin
                        best_val <= next_val;
                        best_idx <= next_idx;
                        cnt      <= cnt + 1'b1;
                        if (last) begin
                            state     <= DONE;
                            o_valid   <= 1'b1;
                            digit     <= next_idx;
                            max_logit <= next_val;
                        end
                    end
                    DONE:    state <= IDLE;
                    IDLE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: latency, tie/sign handling, pending buffer, overflow, reset.
module tb_argmax_classifier;
    import core_pkg::*;

    typedef int vec_t [10];
    typedef struct {
        int cyc;
        int dig;
        int val;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logit_t       logits [10];
    logic         i_ready;
    logic         o_valid;
    logic [3:0]   digit;
    logit_t       max_logit;
    logic         overflow;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_a;
    int   acc_b;
    int   acc_c;
    bit   ready_low_seen;
    res_t res [$];

    vec_t v_main = '{0, 5, -3, 2, 9, 1, 0, -8, 4, 7};
    vec_t v_neg  = '{-10, -2, -7, -2, -30, -5, -9, -4, -3, -6};
    vec_t v_at8  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0};

    argmax_classifier dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .logits    (logits),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .digit     (digit),
        .max_logit (max_logit),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) res.push_back('{cyc, int'(digit), int'(max_logit)});
        if (!i_ready) ready_low_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Drive one vector for a single cycle; acc returns the accepting edge number.
    task automatic pulse(input vec_t v, output int acc);
        for (int i = 0; i < 10; i++) logits[i] = logit_t'(v[i]);
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        res.delete();
        ready_low_seen = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) logits[i] = '0;
        run(3);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_max", int'(max_logit), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_i_ready", int'(i_ready), 1);
        rst = 1'b1;
        run(2);

        // single vector, latency 10
        clear();
        pulse(v_main, acc_a);
        run(14);
        chk("t1_nres", res.size(), 1);
        if (res.size() >= 1) begin
            chk("t1_latency", res[0].cyc + 1 - acc_a, 10);
            chk("t1_digit", res[0].dig, 4);
            chk("t1_max", res[0].val, 9);
        end
        chk("t1_ready_low", int'(ready_low_seen), 0);
        chk("t1_digit_hold", int'(digit), 4);

        // negative values and a tie
        clear();
        pulse(v_neg, acc_a);
        run(14);
        chk("t2_nres", res.size(), 1);
        if (res.size() >= 1) begin
            chk("t2_digit", res[0].dig, 1);
            chk("t2_max", res[0].val, -2);
        end

        // second vector 3 cycles after the first goes to pending
        clear();
        pulse(v_main, acc_a);
        run(2);
        pulse(v_at8, acc_b);
        @(negedge clk);
        chk("t3_i_ready_busy", int'(i_ready), 0);
        run(24);
        chk("t3_nres", res.size(), 2);
        if (res.size() >= 2) begin
            chk("t3_digit0", res[0].dig, 4);
            chk("t3_digit1", res[1].dig, 8);
            chk("t3_max1", res[1].val, 9);
            chk("t3_gap", res[1].cyc - res[0].cyc, 10);
        end
        chk("t3_overflow", int'(overflow), 0);
        chk("t3_i_ready_end", int'(i_ready), 1);

        // input during DONE with pending empty: no idle bubble
        clear();
        pulse(v_main, acc_a);
        for (int i = 0; i < 30 && !o_valid; i++) @(negedge clk);
        pulse(v_neg, acc_b);
        run(14);
        chk("t5_nres", res.size(), 2);
        if (res.size() >= 2) begin
            chk("t5_digit0", res[0].dig, 4);
            chk("t5_digit1", res[1].dig, 1);
            chk("t5_gap", res[1].cyc - res[0].cyc, 10);
            chk("t5_latency1", res[1].cyc + 1 - acc_b, 10);
        end

        // three consecutive vectors: third dropped
        clear();
        pulse(v_main, acc_a);
        pulse(v_neg, acc_b);
        pulse(v_at8, acc_c);
        @(negedge clk);
        chk("t4_overflow_set", int'(overflow), 1);
        run(26);
        chk("t4_nres", res.size(), 2);
        if (res.size() >= 2) begin
            chk("t4_digit0", res[0].dig, 4);
            chk("t4_digit1", res[1].dig, 1);
            chk("t4_max1", res[1].val, -2);
        end
        chk("t4_overflow_held", int'(overflow), 1);
        chk("t4_i_ready_end", int'(i_ready), 1);

        // reset mid-scan with a pending vector
        clear();
        pulse(v_main, acc_a);
        pulse(v_at8, acc_b);
        run(3);
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        run(15);
        chk("t6_nres", res.size(), 0);
        chk("t6_digit", int'(digit), 0);
        chk("t6_max", int'(max_logit), 0);
        chk("t6_overflow", int'(overflow), 0);
        chk("t6_i_ready", int'(i_ready), 1);
        clear();
        pulse(v_neg, acc_a);
        run(14);
        chk("t6_post_nres", res.size(), 1);
        if (res.size() >= 1) begin
            chk("t6_post_latency", res[0].cyc + 1 - acc_a, 10);
            chk("t6_post_digit", res[0].dig, 1);
            chk("t6_post_max", res[0].val, -2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
